// File: rtl/params_pkg.sv
// Shared sizing constants and FSM state type for the softmax block and its divider.
package params_pkg;

  localparam int unsigned NUM_OF_NODES     = 16;
  localparam int unsigned COEF_DATA_WIDTH  = 8;
  localparam int unsigned ALPHA_DATA_WIDTH = 16;
  localparam int unsigned EXP_WIDTH        = 16;
  localparam int unsigned SUM_WIDTH        = EXP_WIDTH + $clog2(NUM_OF_NODES);
  localparam int unsigned NUM_NODE_WIDTH   = $clog2(NUM_OF_NODES) + 1;
  localparam int unsigned IDX_WIDTH        = $clog2(NUM_OF_NODES);

  localparam int unsigned EXP_MAX     = 65535;
  localparam int unsigned SHIFT_CLAMP = 16;
  localparam int unsigned DIV_ITER    = 17;

  localparam int unsigned SHAMT_WIDTH = $clog2(SHIFT_CLAMP + 1);
  localparam int unsigned QUO_WIDTH   = DIV_ITER;
  localparam int unsigned CNT_WIDTH   = $clog2(DIV_ITER);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAX,
    ST_SUM,
    ST_DIV,
    ST_OUT
  } sm_state_e;

endpackage

// File: rtl/sm_divider.sv
// Restoring divider: quotient_c = floor(dividend * 2^16 / divisor), one bit per cycle.
// done_c/quotient_c are valid combinationally during the final iteration cycle.
module sm_divider
  import params_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] dividend,
  input  logic [SUM_WIDTH-1:0] divisor,
  output logic                 done_c,
  output logic [QUO_WIDTH-1:0] quotient_c
);

  logic                 busy_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [SUM_WIDTH-1:0] rem_q;
  logic [SUM_WIDTH-1:0] divisor_q;
  logic [QUO_WIDTH-1:0] shreg_q;

  logic [SUM_WIDTH:0]   trial_c;
  logic                 ge_c;
  logic [SUM_WIDTH-1:0] rem_n_c;
  logic [QUO_WIDTH-1:0] shreg_n_c;

  // One restoring step; shreg holds remaining dividend bits above, quotient bits below.
  always_comb begin
    trial_c   = {rem_q, shreg_q[QUO_WIDTH-1]};
    ge_c      = (trial_c >= {1'b0, divisor_q});
    rem_n_c   = ge_c ? SUM_WIDTH'(trial_c - {1'b0, divisor_q}) : SUM_WIDTH'(trial_c);
    shreg_n_c = {shreg_q[QUO_WIDTH-2:0], ge_c};
  end

  assign done_c     = busy_q && (cnt_q == CNT_WIDTH'(DIV_ITER - 1));
  assign quotient_c = shreg_n_c;

  // Dividend w*2^16: the bits above the 17 quotient positions seed the remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      shreg_q   <= '0;
    end else if (start && !busy_q) begin
      busy_q    <= 1'b1;
      cnt_q     <= '0;
      rem_q     <= SUM_WIDTH'(dividend >> 1);
      divisor_q <= divisor;
      shreg_q   <= {dividend[0], (QUO_WIDTH-1)'(0)};
    end else if (busy_q) begin
      rem_q   <= rem_n_c;
      shreg_q <= shreg_n_c;
      cnt_q   <= cnt_q + CNT_WIDTH'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax.sv
// Approximate softmax over up to NUM_OF_NODES signed coefficients using power-of-two
// weights: max scan, weight/sum scan, then per-node division into Q0.16 alphas.
module softmax
  import params_pkg::*;
(
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             sm_valid_i,
  output logic                                             sm_ready_o,
  input  logic [NUM_OF_NODES-1:0][COEF_DATA_WIDTH-1:0]     coef_i,
  input  logic [NUM_NODE_WIDTH-1:0]                        num_of_nodes,
  output logic                                             sm_valid_o,
  input  logic                                             sm_ready_i,
  output logic [NUM_OF_NODES-1:0][ALPHA_DATA_WIDTH-1:0]    alpha_o
);

  sm_state_e state_q, state_n;

  logic [NUM_OF_NODES-1:0][COEF_DATA_WIDTH-1:0]  coef_q;
  logic [NUM_OF_NODES-1:0][EXP_WIDTH-1:0]        w_q;
  logic [NUM_OF_NODES-1:0][ALPHA_DATA_WIDTH-1:0] alpha_buf_q;
  logic [NUM_NODE_WIDTH-1:0]                     n_q;
  logic [NUM_NODE_WIDTH-1:0]                     idx_q;
  logic signed [COEF_DATA_WIDTH-1:0]             max_q;
  logic [SUM_WIDTH-1:0]                          sum_q;

  logic                              accept_c;
  logic                              div_start_c;
  logic                              last_c;
  logic [NUM_NODE_WIDTH-1:0]         n_in_c;
  logic [IDX_WIDTH-1:0]              idx_lo_c;
  logic signed [COEF_DATA_WIDTH-1:0] coef_cur_c;
  logic [COEF_DATA_WIDTH:0]          diff_c;
  logic [SHAMT_WIDTH-1:0]            shamt_c;
  logic [EXP_WIDTH-1:0]              w_cur_c;
  logic                              div_done_c;
  logic [QUO_WIDTH-1:0]              quo_c;
  logic [ALPHA_DATA_WIDTH-1:0]       alpha_cur_c;

  always_comb begin
    n_in_c      = (num_of_nodes > NUM_NODE_WIDTH'(NUM_OF_NODES)) ?
                  NUM_NODE_WIDTH'(NUM_OF_NODES) : num_of_nodes;
    idx_lo_c    = idx_q[IDX_WIDTH-1:0];
    last_c      = (idx_q == n_q - NUM_NODE_WIDTH'(1));
    coef_cur_c  = $signed(coef_q[idx_lo_c]);
    // max_q >= every scanned coefficient, so the difference is non-negative.
    diff_c      = {max_q[COEF_DATA_WIDTH-1], max_q} - {coef_cur_c[COEF_DATA_WIDTH-1], coef_cur_c};
    shamt_c     = (diff_c > (COEF_DATA_WIDTH+1)'(SHIFT_CLAMP)) ?
                  SHAMT_WIDTH'(SHIFT_CLAMP) : diff_c[SHAMT_WIDTH-1:0];
    w_cur_c     = EXP_WIDTH'(EXP_MAX) >> shamt_c;
    alpha_cur_c = quo_c[QUO_WIDTH-1] ? '1 : quo_c[ALPHA_DATA_WIDTH-1:0];
  end

  sm_divider u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start_c),
    .dividend   (w_q[idx_lo_c]),
    .divisor    (sum_q),
    .done_c     (div_done_c),
    .quotient_c (quo_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (sm_valid_i) state_n = (n_in_c == '0) ? ST_OUT : ST_MAX;
      ST_MAX:  if (last_c) state_n = ST_SUM;
      ST_SUM:  if (last_c) state_n = ST_DIV;
      ST_DIV:  if (div_done_c && last_c) state_n = ST_OUT;
      ST_OUT:  if (sm_ready_i) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // The divider ignores start while busy, so holding it high in DIV chains nodes back to back.
  always_comb begin
    accept_c    = 1'b0;
    div_start_c = 1'b0;
    case (state_q)
      ST_IDLE: accept_c    = sm_valid_i;
      ST_DIV:  div_start_c = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sm_ready_o  <= 1'b1;
      sm_valid_o  <= 1'b0;
      alpha_o     <= '0;
      coef_q      <= '0;
      w_q         <= '0;
      alpha_buf_q <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
    end else begin
      sm_ready_o <= (state_n == ST_IDLE);
      sm_valid_o <= (state_n == ST_OUT);
      case (state_q)
        ST_IDLE: if (accept_c) begin
          coef_q <= coef_i;
          n_q    <= n_in_c;
          idx_q  <= '0;
          sum_q  <= '0;
          max_q  <= {1'b1, (COEF_DATA_WIDTH-1)'(0)};
          if (n_in_c == '0) alpha_o <= '0;
        end
        ST_MAX: begin
          if (coef_cur_c > max_q) max_q <= coef_cur_c;
          idx_q <= last_c ? '0 : idx_q + NUM_NODE_WIDTH'(1);
        end
        ST_SUM: begin
          w_q[idx_lo_c] <= w_cur_c;
          sum_q         <= sum_q + SUM_WIDTH'(w_cur_c);
          idx_q         <= last_c ? '0 : idx_q + NUM_NODE_WIDTH'(1);
        end
        ST_DIV: if (div_done_c) begin
          alpha_buf_q[idx_lo_c] <= alpha_cur_c;
          if (last_c) begin
            for (int k = 0; k < int'(NUM_OF_NODES); k++) begin
              if (IDX_WIDTH'(k) == idx_lo_c)
                alpha_o[k] <= alpha_cur_c;
              else if (NUM_NODE_WIDTH'(k) < n_q)
                alpha_o[k] <= alpha_buf_q[k];
              else
                alpha_o[k] <= '0;
            end
          end else begin
            idx_q <= idx_q + NUM_NODE_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax.sv
// Bench for softmax: directed corner vectors, mid-division reset and random vectors,
// each compared against a plain-arithmetic softmax model.
module tb_softmax;
  import params_pkg::*;

  typedef logic [NUM_OF_NODES-1:0][COEF_DATA_WIDTH-1:0]  coef_vec_t;
  typedef logic [NUM_OF_NODES-1:0][ALPHA_DATA_WIDTH-1:0] alpha_vec_t;

  localparam int LAT_BUDGET = 400;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      sm_valid_i;
  logic                      sm_ready_o;
  coef_vec_t                 coef_i;
  logic [NUM_NODE_WIDTH-1:0] num_of_nodes;
  logic                      sm_valid_o;
  logic                      sm_ready_i;
  alpha_vec_t                alpha_o;

  int checks = 0;
  int errors = 0;

  softmax dut (
    .clk          (clk),
    .rst          (rst),
    .sm_valid_i   (sm_valid_i),
    .sm_ready_o   (sm_ready_o),
    .coef_i       (coef_i),
    .num_of_nodes (num_of_nodes),
    .sm_valid_o   (sm_valid_o),
    .sm_ready_i   (sm_ready_i),
    .alpha_o      (alpha_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_alpha(string tag, alpha_vec_t exp);
    for (int j = 0; j < int'(NUM_OF_NODES); j++)
      chk($sformatf("%s.alpha[%0d]", tag, j), 64'(alpha_o[j]), 64'(exp[j]));
  endtask

  // softmax with base-2 weights: w = 65535 >> min(max-e, 16), alpha = floor(w*2^16/sum)
  function automatic alpha_vec_t model(int nraw, coef_vec_t c);
    alpha_vec_t a = '0;
    longint w[NUM_OF_NODES];
    longint s = 0;
    longint q;
    int n = (nraw > int'(NUM_OF_NODES)) ? int'(NUM_OF_NODES) : nraw;
    int m = -1000;
    int e;
    int d;
    for (int j = 0; j < n; j++) begin
      e = $signed(c[j]);
      if (e > m) m = e;
    end
    for (int j = 0; j < n; j++) begin
      e = $signed(c[j]);
      d = m - e;
      if (d > 16) d = 16;
      w[j] = 64'd65535 >> d;
      s += w[j];
    end
    for (int j = 0; j < n; j++) begin
      q = (w[j] * 65536) / s;
      if (q > 65535) q = 65535;
      a[j] = 16'(q);
    end
    return a;
  endfunction

  task automatic run_vec(string tag, int nraw, coef_vec_t c, int hold);
    alpha_vec_t exp;
    int lat;
    int n_eff;
    exp   = model(nraw, c);
    n_eff = (nraw > int'(NUM_OF_NODES)) ? int'(NUM_OF_NODES) : nraw;
    chk({tag, ".ready_idle"}, 64'(sm_ready_o), 64'd1);
    sm_ready_i   = 1'b0;
    sm_valid_i   = 1'b1;
    coef_i       = c;
    num_of_nodes = NUM_NODE_WIDTH'(nraw);
    tick();
    sm_valid_i   = 1'b0;
    coef_i       = {$urandom, $urandom, $urandom, $urandom};
    num_of_nodes = NUM_NODE_WIDTH'($urandom);
    chk({tag, ".ready_busy"}, 64'(sm_ready_o), 64'd0);
    lat = 1;
    while (sm_valid_o !== 1'b1 && lat < LAT_BUDGET) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'((n_eff == 0) ? 1 : 20 * n_eff + 1));
    chk_alpha(tag, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, ".valid_hold"}, 64'(sm_valid_o), 64'd1);
      chk({tag, ".ready_hold"}, 64'(sm_ready_o), 64'd0);
      chk_alpha({tag, ".hold"}, exp);
    end
    sm_ready_i = 1'b1;
    tick();
    sm_ready_i = 1'b0;
    chk({tag, ".valid_drop"}, 64'(sm_valid_o), 64'd0);
    chk({tag, ".ready_back"}, 64'(sm_ready_o), 64'd1);
    chk_alpha({tag, ".retain"}, exp);
  endtask

  initial begin
    coef_vec_t c;
    int nraw;
    int seen;
    logic [7:0] base;

    rst          = 1'b1;
    sm_valid_i   = 1'b0;
    sm_ready_i   = 1'b0;
    coef_i       = '0;
    num_of_nodes = '0;
    tick();
    tick();
    chk("reset.valid", 64'(sm_valid_o), 64'd0);
    chk("reset.ready", 64'(sm_ready_o), 64'd1);
    chk_alpha("reset", '0);
    rst = 1'b0;
    tick();

    c = {$urandom, $urandom, $urandom, $urandom};
    c[0] = 8'd5;
    run_vec("n1_sat", 1, c, 0);
    chk("n1_sat.const", 64'(alpha_o[0]), 64'd65535);

    c = {$urandom, $urandom, $urandom, $urandom};
    c[0] = 8'd10; c[1] = 8'd10;
    run_vec("eq_pair", 2, c, 1);
    chk("eq_pair.const0", 64'(alpha_o[0]), 64'd32768);
    chk("eq_pair.const1", 64'(alpha_o[1]), 64'd32768);

    c[0] = 8'd10; c[1] = 8'd9;
    run_vec("diff1", 2, c, 0);
    chk("diff1.const0", 64'(alpha_o[0]), 64'd43690);
    chk("diff1.const1", 64'(alpha_o[1]), 64'd21845);

    c[0] = 8'h80; c[1] = 8'h7f;
    run_vec("clamp", 2, c, 0);
    chk("clamp.const0", 64'(alpha_o[0]), 64'd0);
    chk("clamp.const1", 64'(alpha_o[1]), 64'd65535);

    run_vec("n0", 0, {$urandom, $urandom, $urandom, $urandom}, 5);

    // Reset in the middle of division must discard the vector entirely.
    c = {$urandom, $urandom, $urandom, $urandom};
    sm_valid_i   = 1'b1;
    coef_i       = c;
    num_of_nodes = NUM_NODE_WIDTH'(16);
    tick();
    sm_valid_i = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst.valid", 64'(sm_valid_o), 64'd0);
    chk("mid_rst.ready", 64'(sm_ready_o), 64'd1);
    chk_alpha("mid_rst", '0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst.ready_after", 64'(sm_ready_o), 64'd1);
    seen = 0;
    for (int k = 0; k < 350; k++) begin
      tick();
      if (sm_valid_o === 1'b1) seen++;
    end
    chk("mid_rst.no_partial", 64'(seen), 64'd0);
    chk_alpha("mid_rst.idle", '0);
    c = '0;
    c[0] = 8'd10; c[1] = 8'd10;
    run_vec("post_rst", 2, c, 0);

    for (int r = 0; r < 12; r++) begin
      nraw = $urandom_range(0, 20);
      c    = {$urandom, $urandom, $urandom, $urandom};
      if (r % 2 == 1) begin
        base = 8'($urandom_range(0, 200)) - 8'd100;
        for (int j = 0; j < int'(NUM_OF_NODES); j++)
          c[j] = base + 8'($urandom_range(0, 20));
      end
      run_vec($sformatf("rand%0d", r), nraw, c, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax.md
SOFTMAX -- requirements
Module: softmax

Interface
REQ-001 The design SHALL take the following parameters from params_pkg.
- NUM_OF_NODES, default 16, maximum neighbours per node.
- COEF_DATA_WIDTH, default 8, signed attention coefficient width.
- ALPHA_DATA_WIDTH, default 16, unsigned alpha fraction width (Q0.16).
- EXP_WIDTH, default 16, weight width.
- SUM_WIDTH, default EXP_WIDTH+$clog2(NUM_OF_NODES), accumulator width.
- NUM_NODE_WIDTH, default $clog2(NUM_OF_NODES)+1.
REQ-002 Ports SHALL be as listed below (name, direction, width, meaning).
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- sm_valid_i  in  1  coefficient vector valid.
- sm_ready_o  out  1  block idle, accepts input.
- coef_i  in  [NUM_OF_NODES][COEF_DATA_WIDTH]  signed e_ij.
- num_of_nodes  in  NUM_NODE_WIDTH  active neighbour count.
- sm_valid_o  out  1  alpha vector valid; drives the aggregator's aggr_valid_i.
- sm_ready_i  in  1  the aggregator's aggr_ready_o.
- alpha_o  out  [NUM_OF_NODES][ALPHA_DATA_WIDTH]  normalised weights.

Function
REQ-003 FSM states SHALL be IDLE, MAX, SUM, DIV and OUT; sm_ready_o SHALL be 1 only in IDLE.
REQ-004 IDLE SHALL respond to sm_valid_i & sm_ready_o (cycle 0) as follows.
- Register coef_i and n = min(num_of_nodes, NUM_OF_NODES).
- Go to MAX, or to OUT with alpha all zeros if n==0.
- Inputs are don't-care after the accept cycle.
REQ-005 MAX SHALL scan one node per cycle for n cycles, computing signed max m over nodes 0..n-1.
REQ-006 SUM SHALL scan one node per cycle for n cycles.
- d_j = min(m - e_j, 16), computed unsigned.
- w_j = (2^EXP_WIDTH - 1) >> d_j.
- S = sum of w_j, in SUM_WIDTH bits with no overflow.
REQ-007 DIV SHALL run one node at a time, each node taking 18 cycles (1 load plus 17 restoring iterations).
- alpha_j = floor(w_j * 2^16 / S).
- Quotients of 65536 or more SHALL saturate to 65535.
REQ-008 Nodes j >= n SHALL produce alpha_j = 0.
REQ-009 S SHALL never be 0 when n>=1, because w of the max node is 65535; no divide-by-zero path exists.
REQ-010 Latency SHALL be fixed: sm_valid_o rises at cycle 20n+1 after the accept cycle, or cycle 1 when n==0.
REQ-011 OUT SHALL hold sm_valid_o=1 and alpha_o stable until sm_valid_o & sm_ready_i.
- The next cycle is IDLE with sm_valid_o=0.
- sm_ready_o is not asserted in the same cycle as the handshake (no bypass).
REQ-012 alpha_o SHALL only change on entry to OUT or on reset; it retains its value in IDLE.

Reset
REQ-013 While rst=1, at any state including mid-DIV, the block SHALL go to IDLE.
- sm_valid_o=0, sm_ready_o=1 (ready once rst deasserts), alpha_o all zeros.
- All internal registers, counters and divider state are cleared.
- No partial result is emitted after reset.

Structure
REQ-014 params_pkg SHALL hold the following.
- The parameters above.
- The FSM state enum type.
- The constants EXP_MAX=65535, SHIFT_CLAMP=16 and DIV_ITER=17.
REQ-015 Division SHALL live in a sub-module sm_divider: sequential restoring divider with start/done handshake, a SUM_WIDTH divisor and a 17-bit quotient.

Verification
REQ-016 Scenario: n=1, coef[0]=5. Required: alpha[0]=65535 (saturated), others 0, sm_valid_o at cycle 21.
REQ-017 Scenario: n=2, coef={10,10}. Required: alpha={32768,32768}, sm_valid_o at cycle 41.
REQ-018 Scenario: n=2, coef={10,9}. Required: S=98302, alpha={43690,21845}.
REQ-019 Scenario: n=2, coef={-128,127}. Required: d0 clamped to 16, w0=0, alpha={0,65535}.
REQ-020 Scenario: n=0. Required: sm_valid_o at cycle 1 with all zeros. Then hold sm_ready_i=0 for 5 cycles. Required: alpha_o stable, sm_valid_o=1, sm_ready_o=0; after the handshake, IDLE next cycle.
REQ-021 Scenario: n=16, assert rst for 1 cycle during DIV. Required: sm_valid_o=0, alpha_o=0, sm_ready_o=1 once rst is released. A fresh n=2 {10,10} vector then yields {32768,32768}.
